// File: rtl/sample_capture_pkg.sv
// Shared types and default widths for the sample capture buffer.
package sample_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_START,
    CAPTURE,
    READY,
    READOUT
  } state_e;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 9;
  localparam int CHECKSUM_W     = 16;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: synchronous write, registered 1-cycle read.
module capture_ram
  import sample_capture_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sample_capture_buffer.sv
// Sampling-handshake consumer: requests a window, captures ADC words, serves them back.
// Optional running checksum of captured words is built when CAPTURE_CHECKSUM_EN is defined.
module sample_capture_buffer
  import sample_capture_pkg::*;
#(
  parameter int DATA_NUM          = 405,
  parameter int DATA_W            = DEFAULT_DATA_W,
  parameter int ADDR_W            = DEFAULT_ADDR_W,
  parameter int REQ_PULSE_CNT     = 20,
  parameter int START_TIMEOUT_CNT = 1000
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_start,
  output logic                  out_request_n,
  input  logic                  in_measure_sig,
  input  logic                  in_adc_clk,
  input  logic [DATA_W-1:0]     in_adc_data,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_error,
  output logic [ADDR_W-1:0]     out_sample_cnt,
  input  logic                  in_rd_req,
  output logic [DATA_W-1:0]     out_rd_data,
  output logic                  out_rd_valid,
  output logic                  out_rd_last,
  output logic [CHECKSUM_W-1:0] out_checksum
);

  localparam int REQ_W = $clog2(REQ_PULSE_CNT + 1);
  localparam int TO_W  = $clog2(START_TIMEOUT_CNT + 1);

  localparam logic [REQ_W-1:0]  REQ_LAST = REQ_W'(REQ_PULSE_CNT - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(START_TIMEOUT_CNT - 1);
  localparam logic [ADDR_W-1:0] DEPTH    = ADDR_W'(DATA_NUM);

  state_e            state_q, state_d;
  logic [REQ_W-1:0]  req_cnt_q, req_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] sample_cnt_q, sample_cnt_d;
  logic              request_n_q, request_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              adc_clk_d_q;
  logic              measure_d_q;

  logic              adc_rise;
  logic              measure_fall;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] ram_rd_data;

  assign adc_rise     = in_adc_clk & ~adc_clk_d_q;
  assign measure_fall = measure_d_q & ~in_measure_sig;
  assign wr_en        = (state_q == CAPTURE) && adc_rise && (wr_ptr_q != DEPTH);
  assign rd_en        = (state_q == READY) && in_rd_req && !in_start;

  always_comb begin
    state_d      = state_q;
    req_cnt_d    = req_cnt_q;
    to_cnt_d     = to_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    sample_cnt_d = sample_cnt_q;
    request_n_d  = request_n_q;
    error_d      = 1'b0;
    rd_valid_d   = 1'b0;
    rd_last_d    = 1'b0;

    case (state_q)
      IDLE, READY: begin
        if (in_start) begin
          state_d      = REQ;
          req_cnt_d    = '0;
          wr_ptr_d     = '0;
          sample_cnt_d = '0;
          request_n_d  = 1'b0;
        end else if (state_q == READY && in_rd_req) begin
          state_d    = READOUT;
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_ptr_q == sample_cnt_q - 1'b1);
        end
      end
      REQ: begin
        if (req_cnt_q == REQ_LAST) begin
          state_d     = WAIT_START;
          request_n_d = 1'b1;
          to_cnt_d    = '0;
        end else begin
          req_cnt_d = req_cnt_q + 1'b1;
        end
      end
      WAIT_START: begin
        if (in_measure_sig) begin
          state_d = CAPTURE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        // The write that fills the last slot closes the window in the same cycle.
        if (measure_fall || (wr_en && wr_ptr_d == DEPTH)) begin
          sample_cnt_d = wr_ptr_d;
          rd_ptr_d     = '0;
          state_d      = (wr_ptr_d == '0) ? IDLE : READY;
        end
      end
      READOUT: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = rd_last_q ? IDLE : READY;
      end
      default: begin
        state_d     = IDLE;
        request_n_d = 1'b1;
      end
    endcase

    busy_d = !(state_d inside {IDLE, READY});
    done_d = (state_d == READY);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= IDLE;
      req_cnt_q    <= '0;
      to_cnt_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sample_cnt_q <= '0;
      request_n_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      adc_clk_d_q  <= 1'b0;
      measure_d_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_cnt_q    <= req_cnt_d;
      to_cnt_q     <= to_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sample_cnt_q <= sample_cnt_d;
      request_n_q  <= request_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      adc_clk_d_q  <= in_adc_clk;
      measure_d_q  <= in_measure_sig;
    end
  end

  capture_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (in_clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_q),
    .wr_data(in_adc_data),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_rd_data)
  );

`ifdef CAPTURE_CHECKSUM_EN
  logic                  enter_req;
  logic [CHECKSUM_W-1:0] cksum_q, cksum_d;

  assign enter_req = (state_d == REQ) && (state_q != REQ);

  always_comb begin
    cksum_d = cksum_q;
    if (enter_req) begin
      cksum_d = '0;
    end else if (wr_en) begin
      cksum_d = cksum_q + CHECKSUM_W'(in_adc_data);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign out_checksum = cksum_q;
`else
  assign out_checksum = '0;
`endif

  assign out_request_n  = request_n_q;
  assign out_busy       = busy_q;
  assign out_done       = done_q;
  assign out_error      = error_q;
  assign out_sample_cnt = sample_cnt_q;
  assign out_rd_valid   = rd_valid_q;
  assign out_rd_last    = rd_last_q;
  // RAM output register is not reset, so gate it to keep the bus quiet outside a valid beat.
  assign out_rd_data    = rd_valid_q ? ram_rd_data : '0;

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed self-checking bench for sample_capture_buffer (honours CAPTURE_CHECKSUM_EN).
module tb_sample_capture_buffer;

  localparam int DATA_NUM = 405;
  localparam int REQ_CNT  = 20;
  localparam int TO_CNT   = 1000;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b0;
  logic        in_start = 1'b0;
  logic        out_request_n;
  logic        in_measure_sig = 1'b0;
  logic        in_adc_clk = 1'b0;
  logic [7:0]  in_adc_data = '0;
  logic        out_busy;
  logic        out_done;
  logic        out_error;
  logic [8:0]  out_sample_cnt;
  logic        in_rd_req = 1'b0;
  logic [7:0]  out_rd_data;
  logic        out_rd_valid;
  logic        out_rd_last;
  logic [15:0] out_checksum;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  logic [7:0] pat [512];

  typedef struct {
    int n;
    int base;
    int step;
    int exp_cnt;
    int exp_sum;
  } vec_t;

  vec_t vecs [5];

  sample_capture_buffer #(
    .DATA_NUM         (DATA_NUM),
    .DATA_W           (8),
    .ADDR_W           (9),
    .REQ_PULSE_CNT    (REQ_CNT),
    .START_TIMEOUT_CNT(TO_CNT)
  ) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_start      (in_start),
    .out_request_n (out_request_n),
    .in_measure_sig(in_measure_sig),
    .in_adc_clk    (in_adc_clk),
    .in_adc_data   (in_adc_data),
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_error     (out_error),
    .out_sample_cnt(out_sample_cnt),
    .in_rd_req     (in_rd_req),
    .out_rd_data   (out_rd_data),
    .out_rd_valid  (out_rd_valid),
    .out_rd_last   (out_rd_last),
    .out_checksum  (out_checksum)
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_cksum(input int v);
`ifdef CAPTURE_CHECKSUM_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic start_and_count_req();
    int c;
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    c = 0;
    while (out_request_n == 1'b0 && c < 100) begin
      tick();
      c++;
    end
    check("req_low_cycles", c, REQ_CNT);
  endtask

  task automatic run_capture(input int n, input bit check_ovf);
    start_and_count_req();
    in_measure_sig = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      in_adc_data = pat[i];
      in_adc_clk  = 1'b1;
      tick();
      if (check_ovf && i == DATA_NUM - 2) check("ovf_not_ready_yet", out_done, 0);
      if (check_ovf && i == DATA_NUM - 1) check("ovf_ready_on_last_write", out_done, 1);
      in_adc_clk = 1'b0;
      tick();
    end
    in_measure_sig = 1'b0;
    tick();
    tick();
  endtask

  task automatic readout(input int first, input int cnt);
    for (int i = first; i < cnt; i++) begin
      in_rd_req = 1'b1;
      tick();
      in_rd_req = 1'b0;
      check("rd_valid", out_rd_valid, 1);
      check("rd_data", out_rd_data, pat[i]);
      check("rd_last", out_rd_last, (i == cnt - 1) ? 1 : 0);
      tick();
    end
    check("done_after_readout", out_done, 0);
    check("busy_after_readout", out_busy, 0);
  endtask

  initial begin
    vecs[0] = '{n: 1,   base: 8'h5A, step: 0, exp_cnt: 1,   exp_sum: 16'h005A};
    vecs[1] = '{n: 3,   base: 10,    step: 5, exp_cnt: 3,   exp_sum: 16'h002D};
    vecs[2] = '{n: 0,   base: 0,     step: 0, exp_cnt: 0,   exp_sum: 16'h0000};
    vecs[3] = '{n: 404, base: 0,     step: 1, exp_cnt: 404, exp_sum: 16'hA9FE};
    vecs[4] = '{n: 410, base: 0,     step: 1, exp_cnt: 405, exp_sum: 16'hAA92};

    // Reset state
    in_rst = 1'b1;
    tick();
    tick();
    in_rst = 1'b0;
    check("rst_request_n", out_request_n, 1);
    check("rst_busy", out_busy, 0);
    check("rst_done", out_done, 0);
    check("rst_error", out_error, 0);
    check("rst_rd_valid", out_rd_valid, 0);
    check("rst_rd_last", out_rd_last, 0);
    check("rst_rd_data", out_rd_data, 0);
    check("rst_sample_cnt", out_sample_cnt, 0);
    check("rst_checksum", out_checksum, 0);

    // Start timeout: error 1000 cycles after the request ends, exactly once
    begin
      int c;
      start_and_count_req();
      check("wait_busy", out_busy, 1);
      c = 0;
      while (!out_error && c < 2000) begin
        tick();
        c++;
      end
      check("timeout_cycles", c, TO_CNT);
      check("timeout_error", out_error, 1);
      tick();
      check("timeout_error_single", out_error, 0);
      check("timeout_idle_busy", out_busy, 0);
      check("timeout_idle_done", out_done, 0);
    end

    // Table of acquisitions followed by full readout
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 512; i++) pat[i] = 8'((vecs[v].base + i * vecs[v].step) % 256);
      run_capture(vecs[v].n, vecs[v].n > DATA_NUM);
      check("vec_sample_cnt", out_sample_cnt, vecs[v].exp_cnt);
      check("vec_done", out_done, (vecs[v].exp_cnt != 0) ? 1 : 0);
      check("vec_busy", out_busy, 0);
      check("vec_rd_valid_idle", out_rd_valid, 0);
      check("vec_checksum", out_checksum, exp_cksum(vecs[v].exp_sum));
      if (vecs[v].exp_cnt != 0) readout(0, vecs[v].exp_cnt);
    end

    // Reset in the middle of a capture
    for (int i = 0; i < 512; i++) pat[i] = 8'(i + 7);
    start_and_count_req();
    in_measure_sig = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      in_adc_data = pat[i];
      in_adc_clk  = 1'b1;
      tick();
      in_adc_clk = 1'b0;
      tick();
    end
    check("midcap_busy", out_busy, 1);
    in_measure_sig = 1'b0;
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    check("midrst_busy", out_busy, 0);
    check("midrst_done", out_done, 0);
    check("midrst_request_n", out_request_n, 1);

    // Clean acquisition after reset, with a held read request that must not double-read
    for (int i = 0; i < 512; i++) pat[i] = 8'(10 + 5 * i);
    run_capture(3, 1'b0);
    check("post_rst_cnt", out_sample_cnt, 3);
    check("post_rst_done", out_done, 1);
    in_rd_req = 1'b1;
    tick();
    check("held_req_valid", out_rd_valid, 1);
    check("held_req_data", out_rd_data, pat[0]);
    tick();
    check("held_req_ignored", out_rd_valid, 0);
    in_rd_req = 1'b0;
    tick();
    check("held_req_no_extra", out_rd_valid, 0);
    check("held_req_still_ready", out_done, 1);
    readout(1, 3);

    // Start and read request together in READY: start wins
    run_capture(3, 1'b0);
    check("ovr_ready", out_done, 1);
    in_start  = 1'b1;
    in_rd_req = 1'b1;
    tick();
    in_start  = 1'b0;
    in_rd_req = 1'b0;
    check("ovr_no_valid", out_rd_valid, 0);
    check("ovr_request_low", out_request_n, 0);
    check("ovr_done_drop", out_done, 0);
    tick();
    check("ovr_no_valid_later", out_rd_valid, 0);
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;

    // Checksum wraps into bit 9: FF+FF+01+02 = 0x201
    pat[0] = 8'hFF;
    pat[1] = 8'hFF;
    pat[2] = 8'h01;
    pat[3] = 8'h02;
    run_capture(4, 1'b0);
    check("cks_cnt", out_sample_cnt, 4);
    check("cks_ready", out_checksum, exp_cksum(16'h0201));
    in_rd_req = 1'b1;
    tick();
    in_rd_req = 1'b0;
    check("cks_readout_stable", out_checksum, exp_cksum(16'h0201));
    tick();
    readout(1, 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
